regfile_mp: RTL and testbench

- Parametrised multi-port integer register file. Successor to the single-write, two-read 64-bit regfile.
- Generalised in data width, register count, read-port count and write-port count.
- Adds synchronous reset, optional write-to-read bypass and a per-register pending (scoreboard) bit for issue-stage hazard checks.
- Sits between decode/issue (read, claim) and writeback (write) in the core pipeline.

---
 rtl/regfile_pkg.sv | 39 +++
 rtl/regfile_scoreboard.sv | 55 +++++
 rtl/regfile_mp.sv | 99 +++++++++
 tb/tb_regfile_mp.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 64;
    localparam int NREGS_DEFAULT = 32;
    localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    // Upper bounds used to give wr_select a fixed signature: write ports are
    // padded to NWR_MAX and addresses zero-extended to AW_MAX.
    localparam int NWR_MAX = 4;
    localparam int AW_MAX  = 16;

    typedef logic [AW_DEFAULT-1:0] reg_addr_t;
    typedef logic [AW_MAX-1:0]     addr_ext_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] port;
    } wr_sel_t;

    // Finds the write port that targets addr this cycle. Later ports override
    // earlier ones so the highest index wins. x0 never hits.
    function automatic wr_sel_t wr_select(
        input logic [NWR_MAX-1:0]             we,
        input logic [NWR_MAX-1:0][AW_MAX-1:0] waddr,
        input addr_ext_t                      addr
    );
        wr_sel_t s;
        s = '0;
        for (int j = 0; j < NWR_MAX; j++) begin
            if (we[j] && (addr != '0) && (waddr[j] == addr)) begin
                s.hit  = 1'b1;
                s.port = 2'(j);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: claim sets, write clears, claim wins a tie.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_claim,
    input  logic [AW-1:0]      i_claim_addr,
    input  logic [NREGS-1:0]   i_wr_hit,
    input  logic [NRD*AW-1:0]  i_rd_addr,
    input  logic [NRD-1:0]     i_rd_byp,
    output logic [NREGS-1:0]   o_pending,
    output logic [NRD-1:0]     o_rd_busy
);

    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_next;

    // Next pending vector: a claim overrides a clear of the same register.
    always_comb begin
        w_set = '0;
        if (i_claim) begin
            w_set[i_claim_addr] = 1'b1;
        end
        w_next    = (r_pending | w_set) & ~(i_wr_hit & ~w_set);
        w_next[0] = 1'b0;
    end

    // Pending flops, cleared by reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_next;
        end
    end

    assign o_pending = r_pending;

    // A bypassed read sees the write as already complete, so only a
    // same-cycle claim of that register keeps it busy.
    for (genvar k = 0; k < NRD; k++) begin : g_busy
        logic [AW-1:0] w_addr;
        assign w_addr       = i_rd_addr[k*AW +: AW];
        assign o_rd_busy[k] = (i_reset || (w_addr == '0)) ? 1'b0 :
                              i_rd_byp[k] ? (i_claim && (i_claim_addr == w_addr)) :
                              r_pending[w_addr];
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write bypass and scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NRD*AW-1:0]    i_rd_addr,
    output logic [NRD*XLEN-1:0]  o_rd_data,
    output logic [NRD-1:0]       o_rd_busy,
    input  logic [NWR-1:0]       i_we,
    input  logic [NWR*AW-1:0]    i_wr_addr,
    input  logic [NWR*XLEN-1:0]  i_wr_data,
    input  logic                 i_claim,
    input  logic [AW-1:0]        i_claim_addr,
    output logic [NREGS-1:0]     o_pending
);

    logic [NWR_MAX-1:0]             w_we_ext;
    logic [NWR_MAX-1:0][AW_MAX-1:0] w_waddr_ext;
    logic [XLEN-1:0]                w_wdata_ext [NWR_MAX];
    logic [XLEN-1:0]                w_regs      [NREGS];
    logic [NREGS-1:0]               w_wr_hit;
    logic [NRD-1:0]                 w_rd_byp;

    // Pad the write ports to the fixed width wr_select expects; unused ports
    // are permanently disabled.
    for (genvar j = 0; j < NWR_MAX; j++) begin : g_wext
        if (j < NWR) begin : g_used
            assign w_we_ext[j]    = i_we[j];
            assign w_waddr_ext[j] = addr_ext_t'(i_wr_addr[j*AW +: AW]);
            assign w_wdata_ext[j] = i_wr_data[j*XLEN +: XLEN];
        end else begin : g_unused
            assign w_we_ext[j]    = 1'b0;
            assign w_waddr_ext[j] = '0;
            assign w_wdata_ext[j] = '0;
        end
    end

    // x0 has no storage.
    assign w_regs[0]   = '0;
    assign w_wr_hit[0] = 1'b0;

    for (genvar g = 1; g < NREGS; g++) begin : g_reg
        wr_sel_t         w_sel;
        logic [XLEN-1:0] r_reg;

        assign w_sel       = wr_select(w_we_ext, w_waddr_ext, addr_ext_t'(g));
        assign w_wr_hit[g] = w_sel.hit;

        // Register storage: cleared by reset, loaded from the winning port.
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_reg <= '0;
            end else if (w_sel.hit) begin
                r_reg <= w_wdata_ext[w_sel.port];
            end
        end

        assign w_regs[g] = r_reg;
    end

    // Combinational read ports; the same write selection drives the bypass.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_addr;
        wr_sel_t       w_sel;

        assign w_addr      = i_rd_addr[k*AW +: AW];
        assign w_sel       = wr_select(w_we_ext, w_waddr_ext, addr_ext_t'(w_addr));
        assign w_rd_byp[k] = (BYPASS != 0) && w_sel.hit;
        assign o_rd_data[k*XLEN +: XLEN] =
            (i_reset || (w_addr == '0)) ? '0 :
            w_rd_byp[k] ? w_wdata_ext[w_sel.port] :
            w_regs[w_addr];
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_claim      (i_claim),
        .i_claim_addr (i_claim_addr),
        .i_wr_hit     (w_wr_hit),
        .i_rd_addr    (i_rd_addr),
        .i_rd_byp     (w_rd_byp),
        .o_pending    (o_pending),
        .o_rd_busy    (o_rd_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: one BYPASS=1 and one BYPASS=0 instance share stimulus
// and are compared against an array-based reference model.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NWR-1:0]       we;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*XLEN-1:0]  wr_data;
    logic                 claim;
    logic [AW-1:0]        claim_addr;

    logic [NRD*XLEN-1:0]  rd_data_b, rd_data_n;
    logic [NRD-1:0]       busy_b, busy_n;
    logic [NREGS-1:0]     pend_b, pend_n;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_byp (
        .i_clk(clk), .i_reset(rst), .i_rd_addr(rd_addr), .o_rd_data(rd_data_b),
        .o_rd_busy(busy_b), .i_we(we), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_claim(claim), .i_claim_addr(claim_addr), .o_pending(pend_b)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_nob (
        .i_clk(clk), .i_reset(rst), .i_rd_addr(rd_addr), .o_rd_data(rd_data_n),
        .o_rd_busy(busy_n), .i_we(we), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_claim(claim), .i_claim_addr(claim_addr), .o_pending(pend_n)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference state: architectural values and pending flags.
    logic [XLEN-1:0]  m_mem [NREGS];
    logic [NREGS-1:0] m_pend;

    function automatic int wr_a(int j);
        reg_addr_t a;
        a = wr_addr[j*AW +: AW];
        return int'(a);
    endfunction

    // Value a read of address a should return under the current inputs.
    function automatic logic [XLEN-1:0] exp_data(bit byp, int a);
        if (rst || a == 0) return '0;
        if (byp)
            for (int j = NWR - 1; j >= 0; j--)
                if (we[j] && wr_a(j) == a) return wr_data[j*XLEN +: XLEN];
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(bit byp, int a);
        if (rst || a == 0) return 1'b0;
        if (byp)
            for (int j = 0; j < NWR; j++)
                if (we[j] && wr_a(j) == a) return claim && (int'(claim_addr) == a);
        return m_pend[a];
    endfunction

    task automatic settle();
        #1;
        for (int k = 0; k < NRD; k++) begin
            int a;
            a = int'(rd_addr[k*AW +: AW]);
            check($sformatf("rd_data_byp p%0d a%0d", k, a), rd_data_b[k*XLEN +: XLEN], exp_data(1'b1, a));
            check($sformatf("rd_data_nob p%0d a%0d", k, a), rd_data_n[k*XLEN +: XLEN], exp_data(1'b0, a));
            check($sformatf("rd_busy_byp p%0d a%0d", k, a), 64'(busy_b[k]), 64'(exp_busy(1'b1, a)));
            check($sformatf("rd_busy_nob p%0d a%0d", k, a), 64'(busy_n[k]), 64'(exp_busy(1'b0, a)));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < NREGS; r++) m_mem[r] = '0;
            m_pend = '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && wr_a(j) != 0) begin
                    m_mem[wr_a(j)]  = wr_data[j*XLEN +: XLEN];
                    m_pend[wr_a(j)] = 1'b0;
                end
            end
            if (claim && claim_addr != '0) m_pend[claim_addr] = 1'b1;
        end
        #1;
        check("pending_byp", 64'(pend_b), 64'(m_pend));
        check("pending_nob", 64'(pend_n), 64'(m_pend));
    endtask

    task automatic idle();
        rst   = 1'b0;
        we    = '0;
        claim = 1'b0;
    endtask

    task automatic wr(input int p, input int a, input logic [XLEN-1:0] d);
        we[p]                 = 1'b1;
        wr_addr[p*AW +: AW]   = AW'(a);
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic rd(input int a0, input int a1);
        rd_addr[0 +: AW]  = AW'(a0);
        rd_addr[AW +: AW] = AW'(a1);
    endtask

    initial begin
        for (int r = 0; r < NREGS; r++) m_mem[r] = '0;
        m_pend     = '0;
        rst        = 1'b1;
        we         = '0;
        wr_addr    = '0;
        wr_data    = '0;
        claim      = 1'b0;
        claim_addr = '0;
        rd_addr    = '0;

        // Reset then read back every register.
        rd(1, 2);
        settle();
        tick();
        idle();
        check("reset_pending", 64'(pend_b), 64'd0);
        for (int a = 1; a < NREGS; a += 2) begin
            rd(a, (a + 1) % NREGS);
            settle();
            check("reset_read", rd_data_b[63:0], 64'd0);
            tick();
        end

        // Basic write: bypass visible at once, stored value one cycle later.
        wr(0, 5, 64'hDEAD_BEEF);
        rd(5, 5);
        settle();
        check("byp_same_cycle", rd_data_b[127:64], 64'hDEAD_BEEF);
        check("nobyp_same_cycle", rd_data_n[127:64], 64'd0);
        tick();
        idle();
        settle();
        check("nobyp_next_cycle", rd_data_n[127:64], 64'hDEAD_BEEF);
        tick();

        // x0 ignores writes and claims.
        wr(0, 0, 64'hFFFF);
        claim = 1'b1; claim_addr = '0;
        rd(0, 0);
        settle();
        check("x0_read_byp", rd_data_b[63:0], 64'd0);
        tick();
        idle();
        check("x0_pending", 64'(pend_b[0]), 64'd0);

        // Two ports to the same register: port 1 wins.
        wr(0, 7, 64'd1);
        wr(1, 7, 64'd2);
        rd(7, 7);
        settle();
        check("conflict_bypass", rd_data_b[63:0], 64'd2);
        tick();
        idle();
        settle();
        check("conflict_stored", rd_data_n[63:0], 64'd2);
        tick();

        // Scoreboard: claim, wait, write clears; claim+write keeps pending.
        claim = 1'b1; claim_addr = AW'(9);
        rd(9, 9);
        settle();
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            settle();
            check("sb_busy_held", 64'(busy_b[0]), 64'd1);
            check("sb_pending_held", 64'(pend_b[9]), 64'd1);
            tick();
        end
        wr(0, 9, 64'h42);
        settle();
        check("sb_busy_bypass_clear", 64'(busy_b[0]), 64'd0);
        check("sb_busy_nobyp_hold", 64'(busy_n[0]), 64'd1);
        tick();
        idle();
        check("sb_cleared", 64'(pend_b[9]), 64'd0);
        wr(0, 9, 64'h42);
        claim = 1'b1; claim_addr = AW'(9);
        settle();
        check("sb_claim_write_busy", 64'(busy_b[0]), 64'd1);
        tick();
        idle();
        check("sb_claim_write_pend", 64'(pend_b[9]), 64'd1);
        settle();
        check("sb_claim_write_data", rd_data_n[63:0], 64'h42);
        tick();

        // Reset in the middle of traffic wins over a concurrent write.
        wr(0, 3, 64'h33);
        claim = 1'b1; claim_addr = AW'(4);
        rd(3, 4);
        settle();
        tick();
        idle();
        rst = 1'b1;
        wr(0, 3, 64'h77);
        settle();
        check("reset_hold_data", rd_data_b[63:0], 64'd0);
        check("reset_hold_busy", 64'(busy_b[1]), 64'd0);
        tick();
        idle();
        settle();
        check("post_reset_x3", rd_data_n[63:0], 64'd0);
        check("post_reset_pend", 64'(pend_b), 64'd0);
        tick();

        // Randomized traffic concentrated on a few registers to force hazards.
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int j = 0; j < NWR; j++) begin
                we[j] = $urandom_range(0, 1) != 0;
                wr(j, 0, {$urandom(), $urandom()});
                we[j] = $urandom_range(0, 1) != 0;
                wr_addr[j*AW +: AW] = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            end
            claim      = $urandom_range(0, 2) == 0;
            claim_addr = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            rd($urandom_range(0, 7), $urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            settle();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
